// File: rtl/spi_bridge.sv
// Byte-stream to SPI master bridge: framed host bytes are shifted out on MOSI and the
// MISO byte captured in the same transfer is returned on the IN stream.
module spi_bridge #(
  parameter int NUM_CS    = 1,
  parameter int CLK_DIV   = 1,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [7:0]        out_data_i,
  input  logic              out_valid_i,
  output logic              out_ready_o,
  output logic [7:0]        in_data_o,
  output logic              in_valid_o,
  input  logic              in_ready_i,
  output logic              sck_o,
  output logic [NUM_CS-1:0] csn_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [2:0]        state_o
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);
  localparam logic IDLE_SCK = (CPOL != 0);
  localparam logic SAMPLE_TRAIL = (CPHA != 0);
  localparam logic LSBF = (LSB_FIRST != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_GAP, S_CS_SETUP, S_LOAD, S_SHIFT, S_RESP, S_CS_END
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hcnt;
  logic [3:0]    bcnt;
  logic [4:0]    len_left;
  logic [1:0]    cs_idx, held_idx, hdr_idx;
  logic          hold_q, held;
  logic [7:0]    tx_sr, rx_sr, rx_next;
  logic          timed, tick, out_fire, in_fire, cs_ok, lead;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [1:0] idx);
    logic [NUM_CS-1:0] v;
    for (int i = 0; i < NUM_CS; i++) v[i] = (idx != 2'(i));
    return v;
  endfunction

  function automatic logic head_bit(input logic [7:0] b);
    return LSBF ? b[0] : b[7];
  endfunction

  function automatic logic [7:0] advance(input logic [7:0] b);
    return LSBF ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

  // Both streams use valid/ready: a byte moves on a rising clk edge where valid && ready;
  // valid holds with data stable until it moves, and ready never depends on valid.
  assign out_fire = out_valid_i && out_ready_o;
  assign in_fire  = in_valid_o && in_ready_i;
  assign hdr_idx  = out_data_i[6:5];
  assign timed    = (state == S_CS_GAP) || (state == S_CS_SETUP) ||
                    (state == S_SHIFT) || (state == S_CS_END);
  assign tick     = timed && (hcnt == HLAST);
  assign lead     = !bcnt[0];
  assign cs_ok    = ({1'b0, cs_idx} < 3'(NUM_CS));
  assign rx_next  = LSBF ? {miso_i, rx_sr[7:1]} : {rx_sr[6:0], miso_i};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (out_fire) begin
          if (held && hdr_idx != held_idx) state_nxt = S_CS_GAP;
          else if (held)                   state_nxt = S_LOAD;
          else                             state_nxt = S_CS_SETUP;
        end
      end
      S_CS_GAP:   if (tick) state_nxt = S_CS_SETUP;
      S_CS_SETUP: if (tick) state_nxt = S_LOAD;
      S_LOAD:     if (out_fire) state_nxt = S_SHIFT;
      S_SHIFT:    if (tick && bcnt == 4'd15) state_nxt = S_RESP;
      S_RESP:     if (in_fire) state_nxt = (len_left == 5'd0) ? S_CS_END : S_LOAD;
      S_CS_END:   if (tick) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Gated by reset so the bridge refuses bytes for as long as reset is held.
  always_comb begin
    out_ready_o = rstn_i && ((state == S_IDLE) || (state == S_LOAD));
    state_o     = state;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hcnt       <= '0;
      bcnt       <= '0;
      len_left   <= '0;
      cs_idx     <= '0;
      held_idx   <= '0;
      hold_q     <= 1'b0;
      held       <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      sck_o      <= IDLE_SCK;
      csn_o      <= '1;
      mosi_o     <= 1'b0;
      in_data_o  <= '0;
      in_valid_o <= 1'b0;
    end else begin
      hcnt <= (tick || !timed || state_nxt != state) ? '0 : hcnt + HW'(1);
      case (state)
        S_IDLE: begin
          if (out_fire) begin
            cs_idx   <= hdr_idx;
            hold_q   <= out_data_i[7];
            len_left <= out_data_i[4:0];
            if (held && hdr_idx != held_idx) csn_o <= '1;
            else                             csn_o <= cs_decode(hdr_idx);
          end
        end
        S_CS_GAP: if (tick) csn_o <= cs_decode(cs_idx);
        S_LOAD: begin
          if (out_fire) begin
            bcnt  <= '0;
            rx_sr <= '0;
            // With leading-edge sampling the first bit must already be on MOSI.
            if (SAMPLE_TRAIL) begin
              tx_sr <= out_data_i;
            end else begin
              mosi_o <= head_bit(out_data_i);
              tx_sr  <= advance(out_data_i);
            end
          end
        end
        S_SHIFT: begin
          if (tick) begin
            sck_o <= ~sck_o;
            bcnt  <= bcnt + 4'd1;
            if (lead != SAMPLE_TRAIL) rx_sr <= rx_next;
            if (SAMPLE_TRAIL ? lead : (!lead && bcnt != 4'd15)) begin
              mosi_o <= head_bit(tx_sr);
              tx_sr  <= advance(tx_sr);
            end
            if (bcnt == 4'd15) begin
              in_valid_o <= 1'b1;
              in_data_o  <= !cs_ok ? 8'hFF : (SAMPLE_TRAIL ? rx_next : rx_sr);
            end
          end
        end
        S_RESP: begin
          if (in_fire) begin
            in_valid_o <= 1'b0;
            if (len_left != 5'd0) len_left <= len_left - 5'd1;
          end
        end
        S_CS_END: begin
          if (tick) begin
            held     <= hold_q;
            held_idx <= cs_idx;
            if (!hold_q) csn_o <= '1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
